// File: rtl/ps2_mouse_init_seq.sv
// ps2_mouse_init_seq: PS/2 mouse power-up/restart initialiser (FF, ACK/BAT/ID, F4).
// Define PS2_MOUSE_WHEEL_EN to add the IntelliMouse knock and F2 ID query before F4.
module ps2_mouse_init_seq #(
    parameter logic [23:0] PWRUP_CYCLES   = 24'd2_800_000,
    parameter logic [23:0] TIMEOUT_CYCLES = 24'd14_000_000,
    parameter logic [1:0]  MAX_RETRY      = 2'd3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       restart,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    input  logic       tx_busy,
    input  logic       tx_error,
    output logic [7:0] tx_data,
    output logic       tx_load,
    output logic       seq_active,
    output logic       init_done,
    output logic       init_fail,
    output logic [7:0] mouse_id
);
    typedef enum logic [3:0] {PWRUP, SEND, TXWAIT, WAIT_ACK, WAIT_BAT, WAIT_ID, FAULT, DONE, FAIL} state_t;
    state_t      state, state_nxt;
    logic [23:0] timer, timer_nxt;
    logic [7:0]  cmd, cmd_nxt, tx_data_nxt, mouse_id_nxt;
    logic [1:0]  retry, retry_nxt;
    logic [2:0]  resend, resend_nxt;
    logic        busy_seen, busy_seen_nxt, tx_load_nxt, timeout;
`ifdef PS2_MOUSE_WHEEL_EN
    // step 7 = outside the knock; 0..6 index F3,C8,F3,64,F3,50,F2
    logic [2:0] step, step_nxt;
    function automatic logic [7:0] knock_at(input logic [2:0] s);
        return s == 3'd1 ? 8'hC8 : s == 3'd3 ? 8'h64 : s == 3'd5 ? 8'h50 : s == 3'd6 ? 8'hF2 : 8'hF3;
    endfunction
`endif
    assign timeout    = timer == TIMEOUT_CYCLES;
    assign seq_active = !(state == DONE || state == FAIL);
    assign init_done  = state == DONE;
    assign init_fail  = state == FAIL;
    always_comb begin
        state_nxt    = state;
        cmd_nxt      = cmd;
        retry_nxt    = retry;
        resend_nxt   = resend;
        mouse_id_nxt = mouse_id;
        tx_data_nxt  = tx_data;
        tx_load_nxt  = 1'b0;
`ifdef PS2_MOUSE_WHEEL_EN
        step_nxt     = step;
`endif
        if (restart) begin
            state_nxt  = SEND;
            cmd_nxt    = 8'hFF;
            retry_nxt  = 2'd0;
            resend_nxt = 3'd0;
`ifdef PS2_MOUSE_WHEEL_EN
            step_nxt   = 3'd7;
`endif
        end else begin
            case (state)
                PWRUP: if (timer == PWRUP_CYCLES) begin
                    state_nxt = SEND;
                    cmd_nxt   = 8'hFF;
                end
                SEND: if (!tx_busy) begin
                    tx_load_nxt = 1'b1;
                    tx_data_nxt = cmd;
                    state_nxt   = TXWAIT;
                end
                TXWAIT: if (busy_seen && !tx_busy) state_nxt = tx_error ? FAULT : WAIT_ACK;
                        else if (timeout) state_nxt = FAULT;
                WAIT_ACK: if (rx_valid) begin
                    if (rx_data == 8'hFA) begin
                        resend_nxt = 3'd0;
`ifdef PS2_MOUSE_WHEEL_EN
                        state_nxt = cmd == 8'hFF ? WAIT_BAT : cmd == 8'hF4 ? DONE : step == 3'd6 ? WAIT_ID : SEND;
                        if (cmd != 8'hFF && cmd != 8'hF4 && step != 3'd6) begin
                            step_nxt = step + 3'd1;
                            cmd_nxt  = knock_at(step + 3'd1);
                        end
`else
                        state_nxt = cmd == 8'hFF ? WAIT_BAT : DONE;
`endif
                    end else if (rx_data == 8'hFE && resend != 3'd4) begin
                        resend_nxt = resend + 3'd1;
                        state_nxt  = SEND;
                    end else state_nxt = FAULT;
                end else if (timeout) state_nxt = FAULT;
                WAIT_BAT: if (rx_valid) state_nxt = rx_data == 8'hAA ? WAIT_ID : FAULT;
                          else if (timeout) state_nxt = FAULT;
                WAIT_ID: if (rx_valid) begin
                    mouse_id_nxt = rx_data;
                    state_nxt    = SEND;
`ifdef PS2_MOUSE_WHEEL_EN
                    step_nxt     = step == 3'd7 ? 3'd0 : 3'd7;
                    cmd_nxt      = step == 3'd7 ? 8'hF3 : 8'hF4;
`else
                    cmd_nxt      = 8'hF4;
`endif
                end else if (timeout) state_nxt = FAULT;
                FAULT: begin
                    resend_nxt = 3'd0;
                    cmd_nxt    = 8'hFF;
`ifdef PS2_MOUSE_WHEEL_EN
                    step_nxt   = 3'd7;
`endif
                    state_nxt  = retry == MAX_RETRY ? FAIL : SEND;
                    retry_nxt  = retry == MAX_RETRY ? retry : retry + 2'd1;
                end
                DONE, FAIL: ;
                default: state_nxt = FAULT;
            endcase
        end
        timer_nxt     = state_nxt != state ? 24'd0 : (timer == 24'hFF_FFFF ? timer : timer + 24'd1);
        busy_seen_nxt = state_nxt != state ? 1'b0 : busy_seen | tx_busy;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= PWRUP;
            timer     <= 24'd0;
            cmd       <= 8'hFF;
            retry     <= 2'd0;
            resend    <= 3'd0;
            busy_seen <= 1'b0;
            tx_data   <= 8'h00;
            tx_load   <= 1'b0;
            mouse_id  <= 8'h00;
`ifdef PS2_MOUSE_WHEEL_EN
            step      <= 3'd7;
`endif
        end else begin
            state     <= state_nxt;
            timer     <= timer_nxt;
            cmd       <= cmd_nxt;
            retry     <= retry_nxt;
            resend    <= resend_nxt;
            busy_seen <= busy_seen_nxt;
            tx_data   <= tx_data_nxt;
            tx_load   <= tx_load_nxt;
            mouse_id  <= mouse_id_nxt;
`ifdef PS2_MOUSE_WHEEL_EN
            step      <= step_nxt;
`endif
        end
    end
endmodule

// File: tb/tb_ps2_mouse_init_seq.sv
// tb_ps2_mouse_init_seq: scenario table, hand sequences and random mouse/writer behaviour
// checked against a command-level model of the init sequence.
module tb_ps2_mouse_init_seq;
    localparam int MAXR = 3;
    logic clk = 0, rst_n = 0, restart = 0, rx_valid = 0, tx_busy = 0, tx_error = 0;
    logic [7:0] rx_data = 8'h00;
    logic [7:0] tx_data, mouse_id;
    logic tx_load, seq_active, init_done, init_fail;
    int checks = 0, errors = 0, ncyc = 0;
    logic [7:0] got_q[$], exp_q[$];
    int load_t[$], fall_t[$];
    logic exp_done, exp_fail;
    logic [7:0] exp_id = 8'h00;

    typedef struct {
        int err_at; int fe; int bb; bit silent; bit junk; logic [7:0] id; logic [7:0] wid;
    } pol_t;
    typedef struct { pol_t p; int exp_ff; bit exp_done; } vec_t;
    vec_t vecs[9];

    ps2_mouse_init_seq #(.PWRUP_CYCLES(24'd50), .TIMEOUT_CYCLES(24'd1000)) dut (
        .clk(clk), .rst_n(rst_n), .restart(restart), .rx_data(rx_data), .rx_valid(rx_valid),
        .tx_busy(tx_busy), .tx_error(tx_error), .tx_data(tx_data), .tx_load(tx_load),
        .seq_active(seq_active), .init_done(init_done), .init_fail(init_fail), .mouse_id(mouse_id)
    );

    always #5 clk = ~clk;
    always @(posedge clk) ncyc <= ncyc + 1;

    function automatic vec_t mk(int err_at, int fe, int bb, bit silent, bit junk, logic [7:0] id, int ff, bit done);
        vec_t v;
        v.p.err_at = err_at; v.p.fe = fe; v.p.bb = bb; v.p.silent = silent; v.p.junk = junk;
        v.p.id = id; v.p.wid = 8'h03; v.exp_ff = ff; v.exp_done = done;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h", name, act, exp);
        end
    endtask

    // Command-level reference: each attempt walks the command list; resends, writer errors,
    // silence and bad BAT decide fault/ack; faults consume retries.
    task automatic model(input pol_t p);
        logic [7:0] cl[$];
        int k, fe, bb, retry, fes;
        bit fault;
`ifdef PS2_MOUSE_WHEEL_EN
        cl = {8'hFF, 8'hF3, 8'hC8, 8'hF3, 8'h64, 8'hF3, 8'h50, 8'hF2, 8'hF4};
`else
        cl = {8'hFF, 8'hF4};
`endif
        exp_q.delete();
        k = 0; fe = p.fe; bb = p.bb; retry = 0;
        exp_done = 0; exp_fail = 0;
        forever begin
            fault = 0;
            foreach (cl[i]) begin
                fes = 0;
                forever begin
                    exp_q.push_back(cl[i]);
                    k++;
                    if (k - 1 == p.err_at || p.silent) begin fault = 1; break; end
                    if (cl[i] == 8'hFF && fe > 0) begin
                        fe--; fes++;
                        if (fes == 5) begin fault = 1; break; end
                    end else break;
                end
                if (fault) break;
                if (cl[i] == 8'hFF) begin
                    if (bb > 0) begin bb--; fault = 1; break; end
                    exp_id = p.id;
                end
                if (cl[i] == 8'hF2) exp_id = p.wid;
            end
            if (!fault) begin exp_done = 1; return; end
            if (retry == MAXR) begin exp_fail = 1; return; end
            retry++;
        end
    endtask

    task automatic send(input logic [7:0] b);
        rx_data = b; rx_valid = 1;
        @(negedge clk);
        rx_valid = 0; rx_data = 8'($urandom);
    endtask

    // Acts as writer and mouse until the DUT reports done or fail.
    task automatic run_session(input pol_t p, output int first);
        int cyc, k, fe, bb, t0;
        logic [7:0] b;
        got_q.delete(); load_t.delete(); fall_t.delete();
        cyc = 0; k = 0; fe = p.fe; bb = p.bb; first = -1; t0 = ncyc;
        forever begin
            @(negedge clk);
            cyc++;
            if (init_done || init_fail) break;
            if (ncyc - t0 > 20000 || got_q.size() > 60) begin
                checks++; errors++;
                $display("FAIL session_budget loads=%0d cycles=%0d", got_q.size(), ncyc - t0);
                break;
            end
            if (tx_load) begin
                if (first < 0) first = cyc;
                b = tx_data;
                got_q.push_back(b);
                load_t.push_back(ncyc);
                @(negedge clk);
                chk("load_one_cycle", tx_load, 0);
                tx_busy = 1;
                if (p.junk) send(8'hFA);
                repeat ($urandom_range(1, 4)) @(negedge clk);
                tx_error = (k == p.err_at);
                tx_busy = 0;
                fall_t.push_back(ncyc);
                @(negedge clk);
                tx_error = 0;
                if (k != p.err_at && !p.silent) begin
                    repeat (2) @(negedge clk);
                    if (b == 8'hFF && fe > 0) begin
                        fe--;
                        send(8'hFE);
                    end else begin
                        send(8'hFA);
                        if (b == 8'hFF) begin
                            repeat (2) @(negedge clk);
                            if (bb > 0) begin bb--; send(8'hFC); end
                            else begin send(8'hAA); repeat (2) @(negedge clk); send(p.id); end
                        end else if (b == 8'hF2) begin
                            repeat (2) @(negedge clk);
                            send(p.wid);
                        end
                    end
                end
                k++;
            end
        end
    endtask

    task automatic check_session(input bit use_tab, input int tab_ff, input bit tab_done);
        int nff, n;
        nff = 0; n = 0;
        chk("n_loads", got_q.size(), exp_q.size());
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) chk("tx_byte", got_q[i], exp_q[i]);
        foreach (got_q[i]) nff += (got_q[i] == 8'hFF) ? 1 : 0;
        if (use_tab) begin
            chk("tab_ff_count", nff, tab_ff);
            chk("tab_done", init_done, tab_done);
        end
        chk("init_done", init_done, exp_done);
        chk("init_fail", init_fail, exp_fail);
        chk("seq_active_end", seq_active, 0);
        chk("mouse_id", mouse_id, exp_id);
        repeat (150) begin
            @(negedge clk);
            n += tx_load ? 1 : 0;
            rx_valid = ($urandom_range(0, 7) == 0);
            rx_data = 8'($urandom);
        end
        rx_valid = 0;
        chk("no_extra_load", n, 0);
        chk("outcome_hold", {init_done, init_fail}, {exp_done, exp_fail});
    endtask

    task automatic do_restart();
        @(negedge clk);
        restart = 1;
        @(negedge clk);
        restart = 0;
        chk("restart_done_clr", init_done, 0);
        chk("restart_fail_clr", init_fail, 0);
        chk("restart_active", seq_active, 1);
    endtask

    initial begin
        int first, n;
        bit seen;
        pol_t p;
        vecs[0] = mk(-1, 0, 0, 0, 0, 8'h00, 1, 1);
        vecs[1] = mk(-1, 1, 0, 0, 0, 8'h00, 2, 1);
        vecs[2] = mk(-1, 0, 0, 1, 0, 8'h00, 4, 0);
        vecs[3] = mk( 0, 0, 0, 0, 0, 8'h00, 2, 1);
        vecs[4] = mk(-1, 5, 0, 0, 0, 8'h00, 6, 1);
        vecs[5] = mk(-1, 0, 1, 0, 1, 8'h11, 2, 1);
        vecs[6] = mk(-1, 0, 4, 0, 0, 8'h22, 4, 0);
        vecs[7] = mk(-1, 1, 3, 0, 0, 8'h33, 5, 1);
        vecs[8] = mk( 1, 0, 0, 0, 0, 8'h44, 2, 1);

        tx_busy = 1;
        repeat (3) @(negedge clk);
        chk("rst_tx_data", tx_data, 8'h00);
        chk("rst_tx_load", tx_load, 0);
        chk("rst_seq_active", seq_active, 1);
        chk("rst_init_done", init_done, 0);
        chk("rst_init_fail", init_fail, 0);
        chk("rst_mouse_id", mouse_id, 8'h00);
        rst_n = 1;
        n = 0;
        repeat (80) begin
            @(negedge clk);
            n += tx_load ? 1 : 0;
        end
        chk("no_load_while_busy", n, 0);
        chk("pwrup_active", seq_active, 1);
        tx_busy = 0;

        for (int i = 0; i < 9; i++) begin
            if (i > 0) do_restart();
            model(vecs[i].p);
            run_session(vecs[i].p, first);
            chk("first_load_latency", first, 1);
            if (vecs[i].p.silent)
                for (int j = 1; j < load_t.size(); j++)
                    chk("timeout_gap", (load_t[j] - fall_t[j-1] >= 1000 && load_t[j] - fall_t[j-1] <= 1010), 1);
            check_session(1, vecs[i].exp_ff, vecs[i].exp_done);
        end

        // restart in WAIT_BAT in the same cycle as the AA byte
        do_restart();
        seen = 0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk);
            seen = tx_load;
        end
        chk("mid_first_load", seen, 1);
        chk("mid_first_byte", tx_data, 8'hFF);
        @(negedge clk);
        tx_busy = 1;
        repeat (2) @(negedge clk);
        tx_busy = 0;
        repeat (3) @(negedge clk);
        send(8'hFA);
        repeat (2) @(negedge clk);
        rx_data = 8'hAA; rx_valid = 1; restart = 1;
        @(negedge clk);
        rx_valid = 0; restart = 0;
        chk("mid_active", seq_active, 1);
        chk("mid_not_done", init_done, 0);
        p = mk(-1, 0, 0, 0, 0, 8'h5A, 1, 1).p;
        model(p);
        run_session(p, first);
        chk("mid_restart_load", first, 1);
        check_session(0, 0, 0);

        for (int r = 0; r < 8; r++) begin
            p.err_at = int'($urandom_range(0, 6)) - 1;
            p.fe = $urandom_range(0, 6);
            p.bb = $urandom_range(0, 2);
            p.silent = 0;
            p.junk = 1'($urandom);
            p.id = 8'($urandom);
            p.wid = $urandom_range(0, 1) ? 8'h03 : 8'h00;
            do_restart();
            model(p);
            run_session(p, first);
            chk("rand_first_load", first, 1);
            check_session(0, 0, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
